gcd_arbiter: RTL
================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Parameter: TIMEOUT, 1023, WAIT-state watchdog limit in cycles (used only with GCD_ARB_TIMEOUT_EN).
REQ-003 One clock, asynchronous active-high reset; ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  4  per-requester request
- req_ready  out  4  one-hot accept, requester i
- req_a  in  4*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  4*WIDTH  operand B, same packing
- gcd_start  out  1  one-cycle start pulse to GCD engine
- gcd_a  out  WIDTH  operand A to engine
- gcd_b  out  WIDTH  operand B to engine
- gcd_done  in  1  engine completion
- gcd_result  in  WIDTH  engine result, valid with gcd_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  2  requester index of response
- rsp_data  out  WIDTH  GCD result
- rsp_err  out  1  timeout flag
- busy  out  1  high in any state except IDLE

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one GCD job in flight at a time.
REQ-005 IDLE: if any req_valid bit is set, the grant SHALL go to the first set bit searching upward (mod 4) from ptr+1; req_ready SHALL be combinational, one-hot to the winner, and zero outside IDLE.
REQ-006 On accept (req_valid[g] & req_ready[g]), the block SHALL latch req_a/req_b slice g and id g, then move to ISSUE, or to RESP if the zero-operand rule applies.
REQ-007 Zero-operand rule: if either latched operand is 0, the block SHALL bypass the engine with rsp_data = a | b, so gcd(0,0)=0, and enter RESP on the next cycle.
REQ-008 ISSUE: gcd_start SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-009 gcd_a/gcd_b SHALL hold the latched operands, stable from ISSUE through WAIT.
REQ-010 WAIT: on gcd_done the block SHALL register gcd_result into rsp_data and enter RESP.
REQ-011 gcd_done outside WAIT SHALL be ignored.
REQ-012 RESP: rsp_valid=1 with rsp_id, rsp_data and rsp_err held stable until rsp_ready.
REQ-013 On the cycle rsp_ready is seen in RESP, the block SHALL set ptr to rsp_id and return to IDLE.
REQ-014 Latency: accept at cycle N, gcd_start at N+1, rsp_valid one cycle after gcd_done.
REQ-015 Bypass latency: accept at N, rsp_valid at N+1.
REQ-016 Back-to-back: the next accept SHALL be no earlier than the cycle after response handshake.
REQ-017 The arbitration SHALL be fair: a continuously asserted request SHALL be served within 4 grants.

Reset
REQ-018 rst SHALL asynchronously force IDLE, ptr=3 (requester 0 first), and all outputs 0 (req_ready, gcd_start, gcd_a, gcd_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy).
REQ-019 Reset mid-job SHALL drop the in-flight request with no response; the engine is not notified.

Configuration
REQ-020 Macro GCD_ARB_TIMEOUT_EN defined: a counter clears on WAIT entry; if TIMEOUT cycles elapse without gcd_done, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-021 With GCD_ARB_TIMEOUT_EN defined, a gcd_done on the same cycle as expiry SHALL win, giving a normal response.
REQ-022 Macro GCD_ARB_TIMEOUT_EN undefined: no counter; rsp_err SHALL be constant 0 and WAIT SHALL be held indefinitely.

Verification
REQ-023 Single request: req 1 with a=48, b=18; engine model returns 6 -> one gcd_start pulse with gcd_a=48, gcd_b=18; response rsp_id=1, rsp_data=6, rsp_err=0.
REQ-024 Contention: all four req_valid held after reset -> grant order 0,1,2,3,0.
REQ-025 Contention with a late requester: req 2 asserted after req 0 is served -> req 2 is served before req 0 again.
REQ-026 Zero operand: req 3 with a=0, b=35 -> no gcd_start, rsp_data=35, rsp_valid at N+1; a=0, b=0 -> rsp_data=0.
REQ-027 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data held stable, req_ready=0 throughout, spurious gcd_done ignored.
REQ-028 Reset in WAIT: rst pulsed mid-job -> all outputs 0 immediately; the next request is served from requester 0 priority.
REQ-029 Timeout (macro defined, TIMEOUT=8): gcd_done never asserted -> rsp_err=1, rsp_data=0 exactly 8 cycles after WAIT entry.

Source files
------------

// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
//
// Purpose:
//   Round-robin front end that shares one external GCD engine between four
//   requesters. Only one job is in flight at a time. A job with a zero operand
//   never reaches the engine. Instead it is answered directly with a | b, so
//   gcd(0, x) = x and gcd(0, 0) = 0.
//
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//        IDLE -> RESP (zero-operand bypass)
//
// Configuration macro:
//   GCD_ARB_TIMEOUT_EN - when defined, a watchdog limits the time spent in
//                        WAIT to TIMEOUT cycles. On expiry the block answers
//                        with rsp_err = 1 and rsp_data = 0. If gcd_done arrives
//                        on the expiry cycle, the normal response wins.
//                        When the macro is undefined, rsp_err is tied to 0 and
//                        WAIT is held until gcd_done.
//
// Parameters:
//   WIDTH    operand/result width
//   TIMEOUT  WAIT watchdog limit in cycles (only used with GCD_ARB_TIMEOUT_EN)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   per-requester request
//   req_ready   one-hot accept (combinational, IDLE only)
//   req_a/b     packed operands, requester i at [i*WIDTH +: WIDTH]
//   gcd_start   one-cycle start pulse to the engine
//   gcd_a/b     operands to the engine, held for the whole job
//   gcd_done    engine completion (ignored outside WAIT)
//   gcd_result  engine result, valid with gcd_done
//   rsp_valid   response valid (RESP state)
//   rsp_ready   response accept
//   rsp_id      requester index of the response
//   rsp_data    GCD result
//   rsp_err     timeout flag
//   busy        high in any state except IDLE
// -----------------------------------------------------------------------------
module gcd_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               gcd_start,
  output logic [WIDTH-1:0]   gcd_a,
  output logic [WIDTH-1:0]   gcd_b,
  input  logic               gcd_done,
  input  logic [WIDTH-1:0]   gcd_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Reject nonsensical configurations at elaboration time.
  if (WIDTH < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("gcd_arbiter: WIDTH and TIMEOUT must both be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [1:0]       id_q,    id_d;
  logic [WIDTH-1:0] data_q,  data_d;

`ifdef GCD_ARB_TIMEOUT_EN
  // The counter runs 0 .. TIMEOUT-1 while in WAIT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Unpack the per-requester operand slices.
  logic [WIDTH-1:0] a_slice [4];
  logic [WIDTH-1:0] b_slice [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Round-robin search. Start at ptr+1 and wrap. Requester ptr itself is
  // checked last (k = 4 wraps back onto ptr).
  logic [3:0] grant_vec;
  logic [1:0] grant_idx;
  logic       grant_any;
  logic [1:0] cand;

  always_comb begin
    grant_vec = 4'b0000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant_vec[cand] = 1'b1;
      end
    end
  end

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_zero;

  assign sel_a    = a_slice[grant_idx];
  assign sel_b    = b_slice[grant_idx];
  assign sel_zero = (sel_a == '0) || (sel_b == '0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        // req_ready is one-hot to the winner, so any valid request means an
        // accept this cycle.
        if (grant_any) begin
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = grant_idx;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (sel_zero) begin
            // OR of the operands yields the non-zero one, or 0 if both are 0.
            data_d  = sel_a | sel_b;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        if (gcd_done) begin
          // Completion takes priority over a watchdog expiry on the same cycle.
          data_d  = gcd_result;
          state_d = RESP;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end

      RESP: begin
        if (rsp_ready) begin
          // The requester just served gets the lowest priority next time.
          ptr_d   = id_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 2'd0;
      data_q  <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // The state register reads IDLE during reset. The accept path is therefore
  // also gated by rst, so a pending request cannot raise req_ready while rst
  // is high.
  assign req_ready = (state_q == IDLE && !rst) ? grant_vec : 4'b0000;
  assign gcd_start = (state_q == ISSUE);
  assign gcd_a     = a_q;
  assign gcd_b     = b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != IDLE);
`ifdef GCD_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
